comparator_bank: RTL
====================

COMPARATOR_BANK -- requirements
Module: comparator_bank

Interface
REQ-001 Parameter WIDTH, default 24, bit width of compared value and thresholds.
REQ-002 Parameter CHANNELS, default 4, number of independent compare channels (1..16).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port srst  input  1  reset, synchronous and active-high.
REQ-005 Port ena  input  1  compare enable; low freezes match/event/flag/armed state.
REQ-006 Port value  input  WIDTH  unsigned running value (e.g. angle counter) compared by every channel.
REQ-007 Port upd  input  1  strobe: copies every shadow threshold and mode to its active register.
REQ-008 Port wr_en  input  1  write strobe for one channel's shadow threshold and mode.
REQ-009 Port wr_ch  input  max(1,$clog2(CHANNELS))  target channel of a write.
REQ-010 Port wr_data  input  WIDTH  shadow threshold written.
REQ-011 Port wr_mode  input  2  shadow mode written: 0 OFF, 1 EQ, 2 GE, 3 LT.
REQ-012 Port arm  input  CHANNELS  per-channel arm pulse.
REQ-013 Port clr  input  CHANNELS  per-channel write-1-to-clear of sticky flag.
REQ-014 Port match  output  CHANNELS  registered compare result per channel.
REQ-015 Port event  output  CHANNELS  one-cycle pulse on armed rising edge of match.
REQ-016 Port flag  output  CHANNELS  sticky event flag.
REQ-017 Port armed  output  CHANNELS  channel armed status.

Function
REQ-018 Compare unsigned value against the channel's active threshold per active mode: EQ value==thr, GE value>=thr, LT value<thr, OFF always 0.
REQ-019 match SHALL be registered: compare of value sampled at edge N appears on match after edge N (1-cycle latency).
REQ-020 event[i] SHALL be 1 for exactly the cycle after the edge where match[i] goes 0->1 while armed[i]=1 and ena=1.
REQ-021 The edge that produces event[i] SHALL clear armed[i] (one-shot) and set flag[i].
REQ-022 arm[i] with ena=1 SHALL set armed[i] at the next edge; arm coincident with an event-producing edge leaves armed[i]=1 (arm wins).
REQ-023 clr[i] SHALL clear flag[i] regardless of ena; clr coincident with event set leaves flag[i]=1 (set wins).
REQ-024 A match already high when arming SHALL NOT produce an event; a fresh 0->1 rising edge is required.
REQ-025 wr_en SHALL update the shadow of channel wr_ch at the next edge regardless of ena; wr_ch >= CHANNELS ignored.
REQ-026 upd SHALL copy all shadows to active registers at the next edge; wr_en and upd on the same edge: active takes the pre-write shadow, shadow takes the new data.
REQ-027 A new active threshold/mode takes effect in the compare of the edge following upd.
REQ-028 ena=0: match, event, flag (except clr), armed hold; event forced 0; upd still honoured.
REQ-029 value wrap-around (max -> 0) SHALL be treated as ordinary unsigned values; no implicit modular compare.

Reset
REQ-030 srst=1 at an edge SHALL clear shadow and active thresholds to 0, modes to OFF, match, event, flag and armed to 0, overriding ena, wr_en, upd, arm and clr.
REQ-031 Reset mid-operation SHALL discard pending event; first compare after release uses OFF modes until upd.

Structure
REQ-032 Shared package comparator_pkg SHALL hold mode typedef cmp_mode_t (OFF, EQ, GE, LT) and mode width constant.
REQ-033 Per-channel logic SHALL be sub-module comparator_channel (shadow, active, compare, match/event/flag/armed), instantiated CHANNELS times via generate.
REQ-034 No combinational path from any input to any output.

Verification
REQ-035 WIDTH=24, CH0 write thr=100 EQ, upd, arm; ramp value 98..102 one per cycle -> match[0]=1 only for cycle after value=100, event[0] single pulse same cycle, flag[0]=1, armed[0]=0.
REQ-036 CH1 GE thr=50 armed while value=60 -> match=1, no event; value 40 then 55 -> one event on the 55 rise.
REQ-037 Write CH2 thr=10 and upd on same edge with prior shadow 7 -> active=7 first, next upd active=10.
REQ-038 clr[0] and event[0] on same edge -> flag[0] stays 1; clr alone next cycle -> flag[0]=0.
REQ-039 ena=0 while value crosses CH0 threshold -> no event, state held; ena=1 -> compare resumes from current value.
REQ-040 srst asserted during armed EQ match -> all outputs 0 next cycle, modes OFF, no event after release until rewrite, upd and arm.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types for the comparator bank: compare mode encoding and its width.
package comparator_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    CMP_OFF = 2'd0,
    CMP_EQ  = 2'd1,
    CMP_GE  = 2'd2,
    CMP_LT  = 2'd3
  } cmp_mode_t;

endpackage

// File: rtl/comparator_channel.sv
// One compare channel: shadow/active threshold and mode, registered match,
// armed one-shot event, and sticky flag. The event output is named evt
// because "event" is a reserved word in SystemVerilog.
module comparator_channel
  import comparator_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             ena,
  input  logic [WIDTH-1:0] value,
  input  logic             upd,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  cmp_mode_t        wr_mode,
  input  logic             arm,
  input  logic             clr,
  output logic             match,
  output logic             evt,
  output logic             flag,
  output logic             armed
);

  logic [WIDTH-1:0] shadow_thr;
  logic [WIDTH-1:0] active_thr;
  cmp_mode_t        shadow_mode;
  cmp_mode_t        active_mode;
  logic             hit_p0;
  logic             rise_p0;

  // Unsigned compare of the running value against the active threshold.
  // Wrap-around is not special-cased: max and 0 are just ordinary values.
  function automatic logic cmp_eval(input cmp_mode_t mode,
                                    input logic [WIDTH-1:0] v,
                                    input logic [WIDTH-1:0] thr);
    case (mode)
      CMP_EQ:  return (v == thr);
      CMP_GE:  return (v >= thr);
      CMP_LT:  return (v < thr);
      default: return 1'b0;
    endcase
  endfunction

  assign hit_p0  = cmp_eval(active_mode, value, active_thr);
  // A fresh 0->1 transition of match while armed and enabled
  assign rise_p0 = ena & armed & ~match & hit_p0;

  // Shadow takes new writes; active copies the pre-write shadow on upd
  always_ff @(posedge clk) begin
    if (srst) begin
      shadow_thr  <= '0;
      shadow_mode <= CMP_OFF;
      active_thr  <= '0;
      active_mode <= CMP_OFF;
    end else begin
      if (wr_sel) begin
        shadow_thr  <= wr_data;
        shadow_mode <= wr_mode;
      end
      if (upd) begin
        active_thr  <= shadow_thr;
        active_mode <= shadow_mode;
      end
    end
  end

  // ---- stage p0 -> p1: registered compare result and event pulse ----
  // match holds while disabled; event is forced low when disabled
  always_ff @(posedge clk) begin
    if (srst) begin
      match <= 1'b0;
      evt   <= 1'b0;
    end else begin
      evt <= rise_p0;
      if (ena) match <= hit_p0;
    end
  end

  // Arm/disarm one-shot and sticky flag; arm beats disarm, set beats clear
  always_ff @(posedge clk) begin
    if (srst) begin
      armed <= 1'b0;
      flag  <= 1'b0;
    end else begin
      if (ena && arm)   armed <= 1'b1;
      else if (rise_p0) armed <= 1'b0;
      if (rise_p0)      flag  <= 1'b1;
      else if (clr)     flag  <= 1'b0;
    end
  end

endmodule

// File: rtl/comparator_bank.sv
// Bank of CHANNELS independent comparators sharing one running value,
// with per-channel shadow programming and a global update strobe.
module comparator_bank
  import comparator_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                ena,
  input  logic [WIDTH-1:0]    value,
  input  logic                upd,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [MODE_W-1:0]   wr_mode,
  input  logic [CHANNELS-1:0] arm,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] match,
  output logic [CHANNELS-1:0] evt,
  output logic [CHANNELS-1:0] flag,
  output logic [CHANNELS-1:0] armed
);

  cmp_mode_t wr_mode_e;
  assign wr_mode_e = cmp_mode_t'(wr_mode);

  // Writes to a channel index beyond the bank never match any wr_sel
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr_en && (wr_ch == CH_W'(i));

    comparator_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .srst    (srst),
      .ena     (ena),
      .value   (value),
      .upd     (upd),
      .wr_sel  (wr_sel),
      .wr_data (wr_data),
      .wr_mode (wr_mode_e),
      .arm     (arm[i]),
      .clr     (clr[i]),
      .match   (match[i]),
      .evt     (evt[i]),
      .flag    (flag[i]),
      .armed   (armed[i])
    );
  end

endmodule
